mvau_ctrl: RTL

- Sequencing controller for the matrix-vector activation unit datapath.
- Accepts SIMD-wide input-activation beats from the AXI-Stream slave and captures each input vector into a local vector buffer.
- Replays the captured vector for the remaining neuron folds.
- Generates weight-memory addresses, accumulator clear/last strobes and datapath issue strobes, and honours datapath backpressure.

---
 rtl/mvau_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/mvau_ctrl.sv
// rtl/mvau_ctrl.sv - MVAU sequencing controller: stream capture, vector replay, weight addressing
// Two-state sequencer over synapse/neuron/vector fold counters; all outputs decode from registers and inputs.
module mvau_ctrl #(
    parameter int MatrixW  = 16,
    parameter int MatrixH  = 8,
    parameter int SIMD     = 4,
    parameter int PE       = 4,
    parameter int ACT_VECS = 4,
    localparam int SF         = MatrixW / SIMD,
    localparam int NF         = MatrixH / PE,
    localparam int WMEM_DEPTH = SF * NF,
    localparam int SF_W       = (SF > 1) ? $clog2(SF) : 1,
    localparam int WA_W       = (WMEM_DEPTH > 1) ? $clog2(WMEM_DEPTH) : 1
) (
    input  logic            aclk,
    input  logic            areset,
    input  logic            s0_axis_tvalid,
    output logic            s0_axis_tready,
    input  logic            dp_stall,
    output logic            dp_valid,
    output logic            src_sel,
    output logic            buf_wen,
    output logic [SF_W-1:0] buf_waddr,
    output logic [SF_W-1:0] buf_raddr,
    output logic [WA_W-1:0] wmem_addr,
    output logic            acc_clr,
    output logic            acc_last,
    output logic            busy,
    output logic            frame_done
);

    localparam int NF_W  = (NF > 1) ? $clog2(NF) : 1;
    localparam int VEC_W = (ACT_VECS > 1) ? $clog2(ACT_VECS) : 1;

    typedef enum logic {
        S_STREAM = 1'b0,
        S_REPLAY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SF_W-1:0]    sf_cnt_q, sf_cnt_d;
    logic [NF_W-1:0]    nf_cnt_q, nf_cnt_d;
    logic [VEC_W-1:0]   vec_cnt_q, vec_cnt_d;

    logic issue;
    logic sf_last, nf_last, vec_last;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q   <= S_STREAM;
            sf_cnt_q  <= '0;
            nf_cnt_q  <= '0;
            vec_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sf_cnt_q  <= sf_cnt_d;
            nf_cnt_q  <= nf_cnt_d;
            vec_cnt_q <= vec_cnt_d;
        end
    end

    assign sf_last  = (sf_cnt_q == SF_W'(SF - 1));
    assign nf_last  = (nf_cnt_q == NF_W'(NF - 1));
    assign vec_last = (vec_cnt_q == VEC_W'(ACT_VECS - 1));

    // tready depends only on state and stall, so tvalid never loops back into it.
    always_comb begin
        state_d   = state_q;
        sf_cnt_d  = sf_cnt_q;
        nf_cnt_d  = nf_cnt_q;
        vec_cnt_d = vec_cnt_q;
        issue     = 1'b0;
        if (state_q == S_STREAM) begin
            issue = s0_axis_tvalid & ~dp_stall;
        end else begin
            issue = ~dp_stall;
        end
        if (issue) begin
            if (!sf_last) begin
                sf_cnt_d = sf_cnt_q + SF_W'(1);
            end else begin
                sf_cnt_d = '0;
                if (!nf_last) begin
                    nf_cnt_d = nf_cnt_q + NF_W'(1);
                    state_d  = S_REPLAY;
                end else begin
                    nf_cnt_d  = '0;
                    state_d   = S_STREAM;
                    vec_cnt_d = vec_last ? '0 : vec_cnt_q + VEC_W'(1);
                end
            end
        end
    end

    // Every output is forced low while reset is held.
    always_comb begin
        s0_axis_tready = 1'b0;
        dp_valid       = 1'b0;
        src_sel        = 1'b0;
        buf_wen        = 1'b0;
        buf_waddr      = '0;
        buf_raddr      = '0;
        wmem_addr      = '0;
        acc_clr        = 1'b0;
        acc_last       = 1'b0;
        busy           = 1'b0;
        frame_done     = 1'b0;
        if (!areset) begin
            s0_axis_tready = (state_q == S_STREAM) & ~dp_stall;
            dp_valid       = issue;
            src_sel        = (state_q == S_REPLAY);
            buf_wen        = (state_q == S_STREAM) & issue;
            buf_waddr      = sf_cnt_q;
            buf_raddr      = sf_cnt_q;
            wmem_addr      = WA_W'(32'(nf_cnt_q) * 32'(SF) + 32'(sf_cnt_q));
            acc_clr        = issue & (sf_cnt_q == '0);
            acc_last       = issue & sf_last;
            busy           = (sf_cnt_q != '0) | (nf_cnt_q != '0);
            frame_done     = issue & sf_last & nf_last & vec_last;
        end
    end

endmodule
